// File: rtl/decode_stage_ctrl.sv
// Decode-stage controller: owns the IF/ID register, performs the valid/ready
// handshake toward fetch and EX, inserts load-use bubbles and squashes the
// stage for a programmable window after a taken branch/jump.
module decode_stage_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic             id_issue,
  input  logic             ex_ready,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             flush,
  output logic             hazard_stall,
  output logic             flushing,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t     state, state_next;
  logic [3:0] flush_cnt;
  logic [6:0] opcode;
  logic       in_flush, rs1_used, rs2_used, hazard, transfer, load;

  // Source-register usage decode and load-use hazard against the EX load
  always_comb begin
    in_flush = (state == FLUSH);
    opcode   = id_instr[6:0];
    rs1_used = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    rs2_used = (opcode == OP_RTYPE || opcode == OP_STORE || opcode == OP_BRANCH);
    hazard   = id_valid && ex_mem_read && (ex_rd != 5'd0) && !in_flush &&
               ((rs1_used && (ex_rd == id_instr[19:15])) ||
                (rs2_used && (ex_rd == id_instr[24:20])));
  end

  // Handshakes toward EX and fetch; fetch input is sunk while flushing
  always_comb begin
    id_issue     = id_valid && !hazard && !in_flush && !flush;
    transfer     = id_issue && ex_ready;
    if_ready     = in_flush || (!flush && (!id_valid || transfer));
    load         = if_valid && if_ready && !in_flush;
    hazard_stall = hazard;
    flushing     = in_flush;
  end

  // Next-state selection; a flush overrides every other transition
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = FLUSH;
    end else begin
      unique case (state)
        RUN:     state_next = hazard ? STALL : RUN;
        STALL:   state_next = hazard ? STALL : RUN;
        FLUSH:   state_next = (flush_cnt == 4'd0) ? RUN : FLUSH;
        default: state_next = RUN;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  // Flush window counter: reloaded by every flush, counts down while in FLUSH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         flush_cnt <= 4'd0;
    else if (flush)                       flush_cnt <= FLUSH_RELOAD;
    else if (in_flush && flush_cnt != 4'd0) flush_cnt <= flush_cnt - 4'd1;
  end

  // IF/ID pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
      id_pc    <= '0;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (load) begin
      id_valid <= 1'b1;
      id_instr <= if_instr;
      id_pc    <= if_pc;
    end else if (transfer) begin
      id_valid <= 1'b0;
    end
  end

  // Saturating count of load-use bubble cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                          stall_count <= '0;
    else if (hazard && stall_count != '1)  stall_count <= stall_count + 1'b1;
  end

endmodule

// File: doc/decode_stage_ctrl.md
# decode_stage_ctrl

Controller for the decode (ID) stage: owns the IF/ID pipeline register that feeds the immediate generator and main decoder, and sequences it. Accepts fetched instructions with a valid/ready handshake and issues them to EX under back-pressure. Detects load-use hazards against the instruction in EX and inserts bubbles. Squashes the stage for a programmable number of cycles after a taken branch/jump flush.

## Interface
- FLUSH_CYCLES, 1: cycles (1..15) the stage discards fetch input after a flush.
- CNT_W, 16: width of the saturating stall counter.
- clk  in  1  clock, rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  fetched instruction.
- if_pc  in  32  PC of fetched instruction.
- if_ready  out  1  ID accepts/consumes fetch input this cycle.
- id_instr  out  32  IF/ID register instruction (to imm_gen/decoder).
- id_pc  out  32  IF/ID register PC.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_issue  out  1  ID offers a real instruction to EX this cycle (0 = bubble).
- ex_ready  in  1  EX accepts ID output this cycle.
- ex_mem_read  in  1  instruction currently in EX is a load.
- ex_rd  in  5  destination register of the EX instruction.
- flush  in  1  taken branch/jump resolved in EX; squash ID and fetch.
- hazard_stall  out  1  load-use bubble inserted this cycle.
- flushing  out  1  stage in FLUSH state.
- stall_count  out  CNT_W  saturating count of load-use bubble cycles.

## Operation
- States: RUN, STALL, FLUSH. Reset -> RUN.
- Source-use decode from id_instr[6:0]: rs1 used unless opcode is LUI (0110111), AUIPC (0010111) or JAL (1101111). rs2 used for R-type (0110011), STORE (0100011) and BRANCH (1100011).
- hazard = id_valid & ex_mem_read & (ex_rd != 0) & ((rs1_used & ex_rd == id_instr[19:15]) | (rs2_used & ex_rd == id_instr[24:20])). Combinational; forced 0 in FLUSH.
- id_issue = id_valid & ~hazard & state != FLUSH & ~flush.
- ID->EX transfer: id_issue & ex_ready.
- if_ready:
  - In FLUSH: 1 (input is sunk).
  - Otherwise: ~flush & (~id_valid | (id_issue & ex_ready)).
- IF->ID load: if_valid & if_ready & state != FLUSH. Writes id_instr, id_pc and sets id_valid=1.
- id_valid clears on transfer without a simultaneous load.
- Transitions:
  - RUN -> STALL when hazard.
  - STALL -> RUN when ~hazard.
  - Any state -> FLUSH when flush.
  - FLUSH -> RUN when the cycle counter expires.
- Flush (highest priority):
  - Next edge: id_valid=0, id_instr=32'h00000013 (NOP), state=FLUSH, counter=FLUSH_CYCLES-1.
  - Each FLUSH cycle: fetch input accepted and dropped; counter decrements.
  - FLUSH at counter 0 -> RUN.
  - flush asserted while in FLUSH reloads the counter.
- hazard_stall = hazard & state != FLUSH. stall_count increments on each such cycle and saturates at all-ones.
- ex_ready=0 with no hazard: ID holds (id_issue stays 1) and if_ready=0.

## Timing
- Reset values: id_valid=0, id_instr=32'h00000013, id_pc=0, state RUN, counter 0, stall_count=0.
- Outputs at reset: id_issue=0, if_ready=1, hazard_stall=0, flushing=0.
- Latency: fetch accepted at edge N appears on id_instr/id_issue after edge N (one cycle).
- Full throughput: one instruction per cycle when ex_ready=1 and no hazard.
- Load-use: exactly one bubble per hazard (ex_mem_read drops once the load leaves EX). id_instr is held stable throughout.
- Flush effect: visible on the next edge. The flush cycle itself issues nothing (id_issue=0) and if_ready=0. Then FLUSH_CYCLES cycles with flushing=1.
- flush together with hazard or ex_ready=0: flush wins; no transfer.
- reset_n deasserted mid-operation: all state returns to reset values immediately (asynchronous); no partial transfer is reported.

## Test plan
- Stream: addi x1, addi x2, add x3 with ex_ready=1 -> id_issue=1 on three consecutive cycles; id_pc tracks 0x0, 0x4, 0x8; stall_count stays 0.
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5) while ID holds add x6,x5,x7 -> hazard_stall=1 and id_issue=0 for one cycle, if_ready=0, stall_count=1. Next cycle (ex_mem_read=0) add issues.
- False hazards:
  - ex_rd=0 with ID "add x1,x0,x0" -> no stall.
  - ex_rd=5 with ID "lui x5,0x12345" -> no stall (rs1 unused).
- Back-pressure: ex_ready=0 for 3 cycles -> id_issue=1, if_ready=0, id_instr unchanged; the transfer occurs on the first cycle with ex_ready=1.
- Flush with FLUSH_CYCLES=2: flush pulse -> id_valid=0 and id_instr=0x00000013 next cycle. flushing=1 for 2 cycles with fetches sunk, then RUN. A second flush during FLUSH extends the window by 2 cycles.
- Reset mid-stall: assert reset_n=0 during STALL -> all outputs at reset values immediately; stall_count=0. Also force 2^CNT_W+5 hazard cycles -> stall_count saturates at all-ones.
